// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath: widths, defaults
// and the saturating add used by the accumulators.
package mac_pkg;

  localparam int PROD_W        = 16;  // width of one multiplier product
  localparam int DEF_ACC_W     = 24;  // default accumulator width
  localparam int DEF_FRAME_LEN = 16;  // default products per frame
  localparam int MAX_ACC_W     = 32;  // widest accumulator sat_add supports

  // Result of one saturating add: clipped sum plus an overflow flag.
  typedef struct packed {
    logic                 ovf;
    logic [MAX_ACC_W-1:0] sum;
  } sat_res_t;

  // Adds an unsigned product to a w-bit accumulator value and clips the
  // result to 2^w-1. The add is done one bit wider than the widest
  // accumulator so the carry out of bit w-1 is never lost.
  function automatic sat_res_t sat_add(input logic [MAX_ACC_W-1:0] a,
                                       input logic [PROD_W-1:0]    b,
                                       input int unsigned          w);
    logic [MAX_ACC_W:0] raw;
    logic [MAX_ACC_W:0] lim;
    sat_res_t           res;
    raw     = {1'b0, a} + {{(MAX_ACC_W + 1 - PROD_W){1'b0}}, b};
    lim     = ((MAX_ACC_W + 1)'(1) << w) - (MAX_ACC_W + 1)'(1);
    res.ovf = (raw > lim);
    res.sum = res.ovf ? lim[MAX_ACC_W-1:0] : raw[MAX_ACC_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/mac_out_reg.sv
// One-entry valid/ready holding register. A load always wins over a drain,
// so a new result can replace one leaving on the same edge without a bubble.
// The caller must only load when the register is empty or being drained.
module mac_out_reg #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Capture on load, empty on handshake, otherwise hold contents stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mac_accum.sv
// Frame accumulator: sums FRAME_LEN unsigned products with saturation and
// hands each finished frame to a one-entry valid/ready output register.
// Only the last sample of a frame can be stalled by a full output register.
module mac_accum
  import mac_pkg::*;
#(
  parameter  int FRAME_LEN = DEF_FRAME_LEN,
  parameter  int ACC_W     = DEF_ACC_W,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_sat,
  output logic              busy
);

  // Control state is derived from the counter and output occupancy.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [1:0]       state;
  logic             last_smp;
  logic             acc_n;
  logic             out_load;
  sat_res_t         add_res;
  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic             unused_sum_bits;

  assign last_smp = (cnt_q == CNT_W'(FRAME_LEN - 1));

  // Classify the current cycle; HOLD means the final sample must wait.
  always_comb begin
    state = ST_IDLE;
    if (last_smp && out_valid && !out_ready) begin
      state = ST_HOLD;
    end else if (cnt_q != '0) begin
      state = ST_ACCUM;
    end
  end

  assign in_ready = !clr && (state != ST_HOLD);
  assign acc_n    = in_valid && in_ready;
  assign out_load = acc_n && last_smp;
  assign busy     = (cnt_q != '0);

  // Saturating add of the incoming product; bits above ACC_W are always zero.
  always_comb begin
    add_res         = sat_add(MAX_ACC_W'(acc_q), in_data, ACC_W);
    sum             = add_res.sum[ACC_W-1:0];
    ovf             = add_res.ovf;
    unused_sum_bits = ^add_res.sum;
  end

  // Next-state for accumulator, sample counter and sticky saturation flag.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr || out_load) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (acc_n) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
      sat_d = sat_q | ovf;
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  mac_out_reg #(
    .W (ACC_W + 1)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (out_load),
    .data_i  ({sat_q | ovf, sum}),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  ({out_sat, out_data})
  );

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: three instances (4/24, 4/16, 16/24) share one input
// stream; a behavioural model per instance predicts handshakes and results,
// and a separate monitor compares each presented result with a scoreboard.
module tb_mac_accum;

  localparam int NDUT = 3;

  function automatic int fl_of(input int i);
    return (i == 2) ? 16 : 4;
  endfunction

  function automatic int aw_of(input int i);
    return (i == 1) ? 16 : 24;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;

  logic        in_ready_w  [NDUT];
  logic        out_valid_w [NDUT];
  logic        out_sat_w   [NDUT];
  logic        busy_w      [NDUT];
  logic [31:0] out_data_w  [NDUT];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      logic [aw_of(gi)-1:0] od;
      mac_accum #(
        .FRAME_LEN (fl_of(gi)),
        .ACC_W     (aw_of(gi))
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[gi]),
        .in_data   (in_data),
        .out_valid (out_valid_w[gi]),
        .out_ready (out_ready),
        .out_data  (od),
        .out_sat   (out_sat_w[gi]),
        .busy      (busy_w[gi])
      );
      assign out_data_w[gi] = 32'(od);
    end
  endgenerate

  // Reference model state: running sum, sticky flag, samples taken, and
  // whether the output register currently holds a result.
  typedef logic [32:0] ent_t;   // {sat, data}
  ent_t   sb [NDUT][$];
  longint m_acc  [NDUT];
  bit     m_sat  [NDUT];
  int     m_k    [NDUT];
  bit     m_full [NDUT];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int i,
                              input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d got=0x%0h exp=0x%0h t=%0t", name, i, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_acc[i]  = 0;
      m_sat[i]  = 1'b0;
      m_k[i]    = 0;
      m_full[i] = 1'b0;
      sb[i].delete();
    end
  endfunction

  // One clock of stimulus; checks handshake outputs and advances the model.
  task automatic cyc(input bit v, input logic [15:0] d, input bit c, input bit r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    clr       = c;
    out_ready = r;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      bit     rdy;
      longint mx;
      ent_t   e;
      rdy = !c && !(m_k[i] == fl_of(i) - 1 && m_full[i] && !r);
      chk("in_ready", i, 64'(in_ready_w[i]), 64'(rdy));
      chk("busy", i, 64'(busy_w[i]), 64'(m_k[i] != 0));
      chk("out_valid", i, 64'(out_valid_w[i]), 64'(m_full[i]));
      if (m_full[i] && r) m_full[i] = 1'b0;
      if (c) begin
        m_acc[i] = 0;
        m_sat[i] = 1'b0;
        m_k[i]   = 0;
      end else if (v && rdy) begin
        mx = (longint'(1) << aw_of(i)) - 1;
        m_acc[i] = m_acc[i] + longint'(d);
        if (m_acc[i] > mx) begin
          m_acc[i] = mx;
          m_sat[i] = 1'b1;
        end
        m_k[i]++;
        if (m_k[i] == fl_of(i)) begin
          e = {m_sat[i], 32'(m_acc[i])};
          sb[i].push_back(e);
          m_acc[i]  = 0;
          m_sat[i]  = 1'b0;
          m_k[i]    = 0;
          m_full[i] = 1'b1;
        end
      end
    end
  endtask

  // Asynchronous reset in the middle of a cycle, checked immediately.
  task automatic mid_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_out_valid", i, 64'(out_valid_w[i]), 64'd0);
      chk("rst_busy", i, 64'(busy_w[i]), 64'd0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the presented result with the scoreboard head and
  // retires it when the downstream handshake completes.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        for (int i = 0; i < NDUT; i++) begin
          if (out_valid_w[i]) begin
            chk("sb_nonempty", i, 64'(sb[i].size() != 0), 64'd1);
            if (sb[i].size() != 0) begin
              chk("out_data", i, 64'(out_data_w[i]), 64'(sb[i][0][31:0]));
              chk("out_sat", i, 64'(out_sat_w[i]), 64'(sb[i][0][32]));
              if (out_ready) begin
                $display("dut%0d result data=0x%0h sat=%0d", i, out_data_w[i], out_sat_w[i]);
                void'(sb[i].pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_out_valid", i, 64'(out_valid_w[i]), 64'd0);
      chk("reset_busy", i, 64'(busy_w[i]), 64'd0);
      chk("reset_out_data", i, 64'(out_data_w[i]), 64'd0);
      chk("reset_out_sat", i, 64'(out_sat_w[i]), 64'd0);
    end
    rst_n = 1'b1;

    // Simple frame 1..4, then ACC_W=16 saturation and a clean follow-up frame.
    cyc(1, 16'd1, 0, 1); cyc(1, 16'd2, 0, 1); cyc(1, 16'd3, 0, 1); cyc(1, 16'd4, 0, 1);
    cyc(0, 16'd0, 0, 1); cyc(0, 16'd0, 0, 1);
    cyc(1, 16'hFFFF, 0, 1); cyc(1, 16'h0001, 0, 1); cyc(1, 16'd0, 0, 1); cyc(1, 16'd0, 0, 1);
    for (int n = 0; n < 4; n++) cyc(1, 16'd1, 0, 1);
    cyc(0, 16'd0, 0, 1); cyc(0, 16'd0, 0, 1);

    // Realign all instances, then 16 maximal products.
    cyc(0, 16'd0, 1, 1);
    for (int n = 0; n < 16; n++) cyc(1, 16'hFE01, 0, 1);
    cyc(0, 16'd0, 0, 1); cyc(0, 16'd0, 0, 1);

    // Backpressure: two frames back-to-back with the output stalled.
    cyc(0, 16'd0, 1, 1);
    for (int n = 0; n < 8; n++) cyc(1, 16'hFE01, 0, 0);
    cyc(1, 16'hFE01, 0, 1);
    for (int n = 0; n < 3; n++) cyc(0, 16'd0, 0, 1);

    // clr mid-frame with a result pending; offered data is dropped.
    cyc(0, 16'd0, 1, 1);
    cyc(1, 16'd1, 0, 0); cyc(1, 16'd2, 0, 0); cyc(1, 16'd3, 0, 0); cyc(1, 16'd4, 0, 0);
    cyc(1, 16'd5, 0, 0); cyc(1, 16'd6, 0, 0); cyc(1, 16'd7, 1, 0);
    for (int n = 0; n < 4; n++) cyc(1, 16'd1, 0, 0);
    cyc(1, 16'd1, 0, 1);
    for (int n = 0; n < 3; n++) cyc(0, 16'd0, 0, 1);

    // Reset mid-frame with a result pending, then a fresh frame.
    cyc(0, 16'd0, 1, 1);
    for (int n = 0; n < 4; n++) cyc(1, 16'd3, 0, 0);
    cyc(1, 16'd9, 0, 0); cyc(1, 16'd9, 0, 0);
    mid_reset();
    for (int n = 0; n < 4; n++) cyc(1, 16'd2, 0, 1);
    cyc(0, 16'd0, 0, 1); cyc(0, 16'd0, 0, 1);

    // Randomised traffic with occasional clr, stalls and one reset.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] d;
      case ($urandom_range(0, 2))
        0:       d = 16'hFFFF - 16'($urandom_range(0, 15));
        1:       d = 16'($urandom);
        default: d = 16'($urandom_range(0, 255));
      endcase
      if (n == 1500) mid_reset();
      cyc(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 2) != 0));
    end

    for (int n = 0; n < 6; n++) cyc(0, 16'd0, 0, 1);
    for (int i = 0; i < NDUT; i++) chk("sb_drained", i, 64'(sb[i].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
